// File: rtl/mm_seq_pkg.sv
// Shared types and sizing helpers for the matrix-multiply tile sequencer.
package mm_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Descriptor fields are sized for the largest supported fold; the top slices them down.
  localparam int STEP_AW_MAX = 24;

  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int fold(input int dim, input int lanes);
    return dim / lanes;
  endfunction

  typedef struct packed {
    logic                   in_src;
    logic [STEP_AW_MAX-1:0] in_addr;
    logic [STEP_AW_MAX-1:0] w_addr;
    logic                   first;
    logic                   last;
  } step_t;

endpackage

// File: rtl/mm_seq_credit_counter.sv
// Saturating up/down counter; a simultaneous inc and dec cancel, and a lone dec at zero flags underflow.
module mm_seq_credit_counter #(
  parameter int         W    = 4,
  parameter logic [W-1:0] MAX  = '1,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_underflow
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= INIT;
    end else if (i_inc && !i_dec) begin
      if (r_count != MAX) r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc) begin
      if (r_count != '0) r_count <= r_count - 1'b1;
    end
  end

  assign o_count     = r_count;
  assign o_underflow = i_dec && !i_inc && (r_count == '0);

endmodule

// File: rtl/mm_tile_sequencer.sv
// Walks rows x neuron-fold x synapse-fold and issues one MAC step descriptor per cycle, throttled by output credits.
// Optional performance counters are enabled with `define MM_SEQ_PERF_EN.
module mm_tile_sequencer
  import mm_seq_pkg::*;
#(
  parameter int SIMD        = 8,
  parameter int PE          = 4,
  parameter int K_DIM       = 768,
  parameter int N_DIM       = 512,
  parameter int ROW_W       = 16,
  parameter int OUT_CREDITS = 4,
  localparam int SF  = fold(K_DIM, SIMD),
  localparam int NF  = fold(N_DIM, PE),
  localparam int IAW = addr_w(SF),
  localparam int WAW = addr_w(SF * NF)
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             cmd_tvalid,
  output logic             cmd_tready,
  input  logic [ROW_W-1:0] cmd_tdata,
  output logic             step_valid,
  input  logic             step_ready,
  output logic             step_in_src,
  output logic [IAW-1:0]   step_in_addr,
  output logic [WAW-1:0]   step_w_addr,
  output logic             step_first,
  output logic             step_last,
  input  logic             out_fire,
  output logic             busy,
  output logic             done,
  output logic             proto_err,
  output logic [1:0]       dbg_state
`ifdef MM_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_busy_cycles,
  output logic [31:0]      perf_stall_cycles
`endif
);

  localparam int NFW = addr_w(NF);
  localparam int CW  = addr_w(OUT_CREDITS + 1);
  localparam int OW  = ROW_W + addr_w(NF) + 1;
  localparam logic [IAW-1:0] SF_LAST = IAW'(SF - 1);
  localparam logic [NFW-1:0] NF_LAST = NFW'(NF - 1);

  state_t           r_state;
  logic [ROW_W-1:0] r_rows;
  logic [ROW_W-1:0] r_row;
  logic [NFW-1:0]   r_nf;
  logic [IAW-1:0]   r_sf;
  logic [WAW-1:0]   r_w_addr;
  logic             r_cmd_tready;
  logic             r_busy;
  logic             r_done;
  logic             r_proto_err;

  logic [CW-1:0] w_credits;
  logic [OW-1:0] w_outstanding;
  logic          w_credit_underflow;
  logic          w_out_underflow;
  logic          w_cmd_fire;
  logic          w_first;
  logic          w_sf_last;
  logic          w_nf_last;
  logic          w_row_last;
  logic          w_step_valid;
  logic          w_fire;
  logic          w_first_fire;
  logic          w_drain_empty;
  step_t         w_step;
  logic          w_unused_step;

  assign w_cmd_fire   = (r_state == S_IDLE) && cmd_tvalid;
  assign w_first      = (r_sf == '0);
  assign w_sf_last    = (r_sf == SF_LAST);
  assign w_nf_last    = (r_nf == NF_LAST);
  assign w_row_last   = (r_row == r_rows - 1'b1);
  // A new accumulation group needs a free output slot before it may start.
  assign w_step_valid = (r_state == S_RUN) && !(w_first && (w_credits == '0));
  assign w_fire       = w_step_valid && step_ready;
  assign w_first_fire = w_fire && w_first;
  assign w_drain_empty = (w_outstanding == '0) || ((w_outstanding == OW'(1)) && out_fire);

  mm_seq_credit_counter #(
    .W    (CW),
    .MAX  (CW'(OUT_CREDITS)),
    .INIT (CW'(OUT_CREDITS))
  ) u_credits (
    .i_clk       (ap_clk),
    .i_rst       (ap_rst),
    .i_inc       (out_fire),
    .i_dec       (w_first_fire),
    .o_count     (w_credits),
    .o_underflow (w_credit_underflow)
  );

  mm_seq_credit_counter #(
    .W    (OW),
    .MAX  ({OW{1'b1}}),
    .INIT ('0)
  ) u_outstanding (
    .i_clk       (ap_clk),
    .i_rst       (ap_rst),
    .i_inc       (w_first_fire),
    .i_dec       (out_fire),
    .o_count     (w_outstanding),
    .o_underflow (w_out_underflow)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state      <= S_IDLE;
      r_rows       <= '0;
      r_row        <= '0;
      r_nf         <= '0;
      r_sf         <= '0;
      r_w_addr     <= '0;
      r_cmd_tready <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_rows       <= cmd_tdata;
            r_row        <= '0;
            r_nf         <= '0;
            r_sf         <= '0;
            r_w_addr     <= '0;
            r_cmd_tready <= 1'b0;
            r_busy       <= 1'b1;
            if (cmd_tdata == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_fire) begin
            // Weight address runs linearly through nf*SF+sf and restarts every row.
            r_w_addr <= (w_sf_last && w_nf_last) ? '0 : r_w_addr + 1'b1;
            if (!w_sf_last) begin
              r_sf <= r_sf + 1'b1;
            end else begin
              r_sf <= '0;
              if (!w_nf_last) begin
                r_nf <= r_nf + 1'b1;
              end else begin
                r_nf <= '0;
                if (w_row_last) r_state <= S_DRAIN;
                else            r_row   <= r_row + 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (w_drain_empty) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_cmd_tready <= 1'b1;
        end
      endcase
    end
  end

  // Credit underflow is unreachable by construction; folding it in keeps a broken count visible.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_proto_err <= 1'b0;
    else if (w_out_underflow || w_credit_underflow) r_proto_err <= 1'b1;
  end

  always_comb begin
    w_step         = '0;
    w_step.in_src  = (r_nf != '0);
    w_step.in_addr = STEP_AW_MAX'(r_sf);
    w_step.w_addr  = STEP_AW_MAX'(r_w_addr);
    w_step.first   = w_first;
    w_step.last    = w_sf_last;
  end

  assign w_unused_step = ^{w_step.in_addr[STEP_AW_MAX-1:IAW], w_step.w_addr[STEP_AW_MAX-1:WAW]};

  assign step_valid   = w_step_valid;
  assign step_in_src  = w_step.in_src;
  assign step_in_addr = w_step.in_addr[IAW-1:0];
  assign step_w_addr  = w_step.w_addr[WAW-1:0];
  assign step_first   = w_step.first;
  assign step_last    = w_step.last;
  assign cmd_tready   = r_cmd_tready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign proto_err    = r_proto_err;
  assign dbg_state    = r_state;

`ifdef MM_SEQ_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else if (w_cmd_fire) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (r_busy && (r_perf_busy != '1)) r_perf_busy <= r_perf_busy + 1'b1;
      if ((r_state == S_RUN) && !w_fire && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_busy_cycles  = r_perf_busy;
  assign perf_stall_cycles = r_perf_stall;
`endif

endmodule
